// File: rtl/router_pkg.sv
// Shared deflection-router constants and id types used by the per-router
// priority logic.
package router_pkg;

    localparam int unsigned NUM_PORT   = 4;
    localparam int unsigned NUM_ARB    = 4;
    localparam int unsigned WIDTH_NODE = 4;
    localparam int unsigned WIDTH_SEQ  = 4;

    // Galois feedback taps for the 16-bit right-shifting LFSR.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef logic [WIDTH_NODE-1:0] node_id_t;
    typedef logic [WIDTH_SEQ-1:0]  seq_id_t;

endpackage

// File: rtl/lfsr_galois16.sv
// 16-bit right-shifting Galois LFSR that advances on every clock.
// It never reaches zero, provided the seed is nonzero.
module lfsr_galois16
    import router_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] state
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    always_comb begin
        state_d = (state_q >> 1) ^ (state_q[0] ? LFSR_TAPS : 16'h0000);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/gold_silver_ctrl.sv
// Per-router priority controller: tracks the golden epoch, tags gold flits,
// selects one silver flit per cycle and supplies arbiter tie-break bits.
module gold_silver_ctrl
    import router_pkg::*;
#(
    parameter int unsigned NUM_PORT   = router_pkg::NUM_PORT,
    parameter int unsigned NUM_ARB    = router_pkg::NUM_ARB,
    parameter int unsigned NUM_NODE   = 16,
    parameter int unsigned WIDTH_NODE = router_pkg::WIDTH_NODE,
    parameter int unsigned WIDTH_SEQ  = router_pkg::WIDTH_SEQ,
    parameter int unsigned EPOCH_LEN  = 64,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            en,
    input  logic [NUM_PORT-1:0]             vld_in,
    input  logic [NUM_PORT*WIDTH_NODE-1:0]  src_in,
    input  logic [NUM_PORT*WIDTH_SEQ-1:0]   seq_in,
    output logic [NUM_PORT-1:0]             gold_out,
    output logic [NUM_PORT-1:0]             silver_out,
    output logic [NUM_ARB-1:0]              rand_out,
    output logic [WIDTH_NODE-1:0]           golden_src,
    output logic [WIDTH_SEQ-1:0]            golden_seq,
    output logic                            epoch_tick
);

    localparam int unsigned CNT_W   = $clog2(EPOCH_LEN);
    localparam int unsigned START_W = $clog2(NUM_PORT);

    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(EPOCH_LEN - 1);
    localparam logic [WIDTH_NODE-1:0] SRC_LAST = WIDTH_NODE'(NUM_NODE - 1);

    logic [CNT_W-1:0]      epoch_cnt_q, epoch_cnt_d;
    logic [WIDTH_NODE-1:0] golden_src_q, golden_src_d;
    logic [WIDTH_SEQ-1:0]  golden_seq_q, golden_seq_d;
    logic                  epoch_tick_q, epoch_tick_d;

    logic [15:0]           lfsr_state;
    logic [START_W-1:0]    start;
    logic                  lfsr_unused;

    logic [NUM_PORT-1:0]   cand;
    logic [NUM_PORT-1:0]   cand_rot;
    logic [NUM_PORT-1:0]   pick_rot;
    logic                  found;

    lfsr_galois16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .state (lfsr_state)
    );

    assign rand_out    = lfsr_state[NUM_ARB-1:0];
    assign start       = lfsr_state[NUM_ARB +: START_W];
    assign lfsr_unused = ^lfsr_state;

    // Epoch state; the source id advances only when the sequence id wraps.
    always_comb begin
        epoch_cnt_d  = epoch_cnt_q;
        golden_src_d = golden_src_q;
        golden_seq_d = golden_seq_q;
        epoch_tick_d = 1'b0;
        if (en) begin
            if (epoch_cnt_q == CNT_LAST) begin
                epoch_cnt_d  = '0;
                epoch_tick_d = 1'b1;
                golden_seq_d = golden_seq_q + 1'b1;
                if (golden_seq_q == '1) begin
                    golden_src_d = (golden_src_q == SRC_LAST) ? '0 : golden_src_q + 1'b1;
                end
            end else begin
                epoch_cnt_d = epoch_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            epoch_cnt_q  <= '0;
            golden_src_q <= '0;
            golden_seq_q <= '0;
            epoch_tick_q <= 1'b0;
        end else begin
            epoch_cnt_q  <= epoch_cnt_d;
            golden_src_q <= golden_src_d;
            golden_seq_q <= golden_seq_d;
            epoch_tick_q <= epoch_tick_d;
        end
    end

    assign golden_src = golden_src_q;
    assign golden_seq = golden_seq_q;
    assign epoch_tick = epoch_tick_q;

    always_comb begin
        gold_out = '0;
        for (int unsigned i = 0; i < NUM_PORT; i++) begin
            gold_out[i] = vld_in[i]
                        && (src_in[i*WIDTH_NODE +: WIDTH_NODE] == golden_src_q)
                        && (seq_in[i*WIDTH_SEQ +: WIDTH_SEQ] == golden_seq_q);
        end
    end

    // Rotate candidates so the start port sits at bit 0, take the lowest set
    // bit, then rotate the grant back to physical port numbering.
    always_comb begin
        cand       = vld_in & ~gold_out;
        cand_rot   = '0;
        pick_rot   = '0;
        silver_out = '0;
        found      = 1'b0;
        for (int unsigned k = 0; k < NUM_PORT; k++) begin
            cand_rot[k] = cand[(32'(start) + k) % NUM_PORT];
        end
        for (int unsigned k = 0; k < NUM_PORT; k++) begin
            if (!found && cand_rot[k]) begin
                pick_rot[k] = 1'b1;
                found       = 1'b1;
            end
        end
        for (int unsigned k = 0; k < NUM_PORT; k++) begin
            if (pick_rot[k]) begin
                silver_out[(32'(start) + k) % NUM_PORT] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gold_silver_ctrl.sv
// Directed bench for gold_silver_ctrl using a short epoch (4 cycles),
// 2-bit sequence ids and a 3-node ring so that wraps are reachable quickly.
module tb_gold_silver_ctrl;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [3:0]  vld_in;
    logic [15:0] src_in;
    logic [7:0]  seq_in;
    logic [3:0]  gold_out;
    logic [3:0]  silver_out;
    logic [3:0]  rand_out;
    logic [3:0]  golden_src;
    logic [1:0]  golden_seq;
    logic        epoch_tick;

    int errors = 0;
    int checks = 0;

    gold_silver_ctrl #(
        .NUM_PORT   (4),
        .NUM_ARB    (4),
        .NUM_NODE   (3),
        .WIDTH_NODE (4),
        .WIDTH_SEQ  (2),
        .EPOCH_LEN  (4),
        .LFSR_SEED  (16'hACE1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .vld_in     (vld_in),
        .src_in     (src_in),
        .seq_in     (seq_in),
        .gold_out   (gold_out),
        .silver_out (silver_out),
        .rand_out   (rand_out),
        .golden_src (golden_src),
        .golden_seq (golden_seq),
        .epoch_tick (epoch_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit expired, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic do_reset(input logic en_v);
        en = en_v;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        logic [3:0] exp_rand [6] = '{4'h0, 4'h8, 4'hC, 4'hE, 4'h7, 4'h3};
        en = 1'b0;
        vld_in = '0; src_in = '0; seq_in = '0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (rand_out !== 4'b0001) begin
            $display("FAIL reset_rand: got %b want 0001", rand_out); errors++;
        end
        checks++;
        if (golden_src !== 4'd0 || golden_seq !== 2'd0 || epoch_tick !== 1'b0) begin
            $display("FAIL reset_state: got src=%0d seq=%0d tick=%b want 0 0 0",
                     golden_src, golden_seq, epoch_tick); errors++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checks++;
            if (rand_out !== exp_rand[i]) begin
                $display("FAIL lfsr_step%0d: got %h want %h", i + 1, rand_out, exp_rand[i]); errors++;
            end
        end
    endtask

    task automatic test_silver;
        do_reset(1'b0);
        src_in = 16'h2222; seq_in = 8'h00;
        // start = 2
        vld_in = 4'b1111; #1;
        checks++;
        if (silver_out !== 4'b0100) begin
            $display("FAIL silver_s2_all: got %b want 0100", silver_out); errors++;
        end
        vld_in = 4'b0011; #1;
        checks++;
        if (silver_out !== 4'b0001) begin
            $display("FAIL silver_s2_0011: got %b want 0001", silver_out); errors++;
        end
        // start = 3
        @(posedge clk); #1;
        vld_in = 4'b1111; #1;
        checks++;
        if (silver_out !== 4'b1000) begin
            $display("FAIL silver_s3_all: got %b want 1000", silver_out); errors++;
        end
        vld_in = 4'b0011; #1;
        checks++;
        if (silver_out !== 4'b0001) begin
            $display("FAIL silver_s3_0011: got %b want 0001", silver_out); errors++;
        end
        // start = 3 again (lfsr 7138)
        @(posedge clk); #1;
        vld_in = 4'b0110; #1;
        checks++;
        if (silver_out !== 4'b0010) begin
            $display("FAIL silver_s3_0110: got %b want 0010", silver_out); errors++;
        end
        // start = 1 (lfsr 389C)
        @(posedge clk); #1;
        vld_in = 4'b1111; #1;
        checks++;
        if (silver_out !== 4'b0010) begin
            $display("FAIL silver_s1_all: got %b want 0010", silver_out); errors++;
        end
        vld_in = 4'b1000; #1;
        checks++;
        if (silver_out !== 4'b1000) begin
            $display("FAIL silver_s1_1000: got %b want 1000", silver_out); errors++;
        end
        vld_in = 4'b0000; #1;
        checks++;
        if (silver_out !== 4'b0000 || gold_out !== 4'b0000) begin
            $display("FAIL silver_none: got silver=%b gold=%b want 0000 0000", silver_out, gold_out); errors++;
        end
    endtask

    task automatic test_gold;
        do_reset(1'b0);
        // port 2 carries golden (0,0); others carry src 2
        src_in = 16'h2022; seq_in = 8'h00;
        vld_in = 4'b0100; #1;
        checks++;
        if (gold_out !== 4'b0100 || silver_out !== 4'b0000) begin
            $display("FAIL gold_single: got gold=%b silver=%b want 0100 0000", gold_out, silver_out); errors++;
        end
        // start = 2, port 2 is gold so silver moves on to port 3
        vld_in = 4'b1100; #1;
        checks++;
        if (gold_out !== 4'b0100 || silver_out !== 4'b1000) begin
            $display("FAIL gold_skip: got gold=%b silver=%b want 0100 1000", gold_out, silver_out); errors++;
        end
        vld_in = 4'b0000; #1;
        checks++;
        if (gold_out !== 4'b0000) begin
            $display("FAIL gold_invalid: got %b want 0000", gold_out); errors++;
        end
        src_in = 16'h0000;
        vld_in = 4'b1111; #1;
        checks++;
        if (gold_out !== 4'b1111 || silver_out !== 4'b0000) begin
            $display("FAIL gold_multi: got gold=%b silver=%b want 1111 0000", gold_out, silver_out); errors++;
        end
        seq_in = 8'b01_00_00_00;
        vld_in = 4'b1000; #1;
        checks++;
        if (gold_out !== 4'b0000 || silver_out !== 4'b1000) begin
            $display("FAIL gold_seq_mismatch: got gold=%b silver=%b want 0000 1000", gold_out, silver_out); errors++;
        end
        vld_in = 4'b0000; src_in = '0; seq_in = '0;
    endtask

    task automatic test_epoch_wrap;
        int exp_seq, exp_src;
        logic exp_tick;
        do_reset(1'b1);
        for (int n = 1; n <= 48; n++) begin
            @(posedge clk); #1;
            exp_tick = (n % 4 == 0);
            exp_seq  = (n / 4) % 4;
            exp_src  = (n / 16) % 3;
            checks++;
            if (epoch_tick !== exp_tick || golden_seq !== 2'(exp_seq) || golden_src !== 4'(exp_src)) begin
                $display("FAIL epoch_n%0d: got tick=%b src=%0d seq=%0d want tick=%b src=%0d seq=%0d",
                         n, epoch_tick, golden_src, golden_seq, exp_tick, exp_src, exp_seq); errors++;
            end
        end
    endtask

    task automatic test_freeze;
        logic [3:0] prev_rand;
        int changes;
        do_reset(1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        en = 1'b0;
        prev_rand = rand_out;
        changes = 0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            checks++;
            if (epoch_tick !== 1'b0 || golden_src !== 4'd0 || golden_seq !== 2'd0) begin
                $display("FAIL freeze_c%0d: got tick=%b src=%0d seq=%0d want 0 0 0",
                         n, epoch_tick, golden_src, golden_seq); errors++;
            end
            if (rand_out !== prev_rand) changes++;
            prev_rand = rand_out;
        end
        checks++;
        if (changes == 0) begin
            $display("FAIL freeze_rand: got %0d rand changes want >0", changes); errors++;
        end
        en = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (epoch_tick !== 1'b0 || golden_seq !== 2'd0) begin
            $display("FAIL resume_cnt3: got tick=%b seq=%0d want 0 0", epoch_tick, golden_seq); errors++;
        end
        @(posedge clk); #1;
        checks++;
        if (epoch_tick !== 1'b1 || golden_seq !== 2'd1) begin
            $display("FAIL resume_wrap: got tick=%b seq=%0d want 1 1", epoch_tick, golden_seq); errors++;
        end
    endtask

    task automatic test_async_reset;
        do_reset(1'b1);
        repeat (72) @(posedge clk);
        #1;
        checks++;
        if (golden_src !== 4'd1 || golden_seq !== 2'd2 || epoch_tick !== 1'b1) begin
            $display("FAIL async_pre: got src=%0d seq=%0d tick=%b want 1 2 1",
                     golden_src, golden_seq, epoch_tick); errors++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (golden_src !== 4'd0 || golden_seq !== 2'd0 || epoch_tick !== 1'b0 || rand_out !== 4'b0001) begin
            $display("FAIL async_reset: got src=%0d seq=%0d tick=%b rand=%b want 0 0 0 0001",
                     golden_src, golden_seq, epoch_tick, rand_out); errors++;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b1;
        en     = 1'b0;
        vld_in = '0;
        src_in = '0;
        seq_in = '0;
        test_reset();
        test_silver();
        test_gold();
        test_epoch_wrap();
        test_freeze();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
